// File: rtl/seg_display_sched.sv
// seg_display_sched: picks the seven-segment pattern from prioritised sources, a sticky LOSE
// override and a timed page sequencer, with per-digit blinking.
module seg_display_sched #(
    parameter int N_SRC        = 4,
    parameter int N_DIG        = 4,
    parameter int N_PAGE       = 4,
    parameter int PAGE_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic                         Clk100M,
    input  logic                         Rst_n,
    input  logic [N_SRC-1:0]             srcValid,
    input  logic [N_SRC*N_DIG*8-1:0]     srcSegs,
    input  logic                         lose,
    input  logic                         clearLose,
    input  logic [N_PAGE*N_DIG*8-1:0]    pageSegs,
    input  logic                         pageStart,
    input  logic                         pageStop,
    input  logic [N_DIG-1:0]             blinkMask,
    output logic [N_DIG*8-1:0]           segOut,
    output logic [$clog2(N_SRC+2)-1:0]   srcSel,
    output logic [$clog2(N_PAGE)-1:0]    pageIdx,
    output logic                         pageDone,
    output logic                         loseActive
);
    localparam int SW  = $clog2(N_SRC+2);
    localparam int PW  = $clog2(N_PAGE);
    localparam int PCW = PAGE_CYCLES > 1 ? $clog2(PAGE_CYCLES) : 1;
    localparam int BCW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, PAGING, HOLD} stateT;
    stateT state, stateNxt;
    logic [PW-1:0] pageIdxNxt;
    logic [PCW-1:0] pageCnt, pageCntNxt;
    logic [BCW-1:0] blinkCnt, blinkCntNxt;
    logic blinkOn, blinkNxt, loseNxt, paging, isNone;
    logic [N_DIG*8-1:0] srcPick, content, blinked, loseSegs, segNxt;
    logic [SW-1:0] selPick, selNxt;
    always_comb begin
        stateNxt   = state;
        pageIdxNxt = pageIdx;
        pageCntNxt = pageCnt;
        if (pageStart) begin
            stateNxt   = PAGING;
            pageIdxNxt = '0;
            pageCntNxt = '0;
        end else if (pageStop) begin
            stateNxt   = IDLE;
            pageIdxNxt = '0;
            pageCntNxt = '0;
        end else if (state == PAGING) begin
            pageCntNxt = pageCnt == PCW'(PAGE_CYCLES-1) ? '0 : pageCnt + 1'b1;
            if (pageCnt == PCW'(PAGE_CYCLES-1)) begin
                if (pageIdx == PW'(N_PAGE-1)) stateNxt = HOLD;
                else pageIdxNxt = pageIdx + 1'b1;
            end
        end
    end
    assign blinkCntNxt = blinkCnt == BCW'(BLINK_CYCLES-1) ? '0 : blinkCnt + 1'b1;
    assign blinkNxt    = blinkCnt == BCW'(BLINK_CYCLES-1) ? ~blinkOn : blinkOn;
    assign loseNxt     = lose | (loseActive & ~clearLose);
    assign paging      = stateNxt != IDLE;
    assign isNone      = !paging && srcValid == '0;
    // Reverse scan so the lowest-index valid source is the one left standing.
    always_comb begin
        srcPick = '0;
        selPick = SW'(N_SRC+1);
        for (int s = N_SRC-1; s >= 0; s--)
            if (srcValid[s]) begin
                srcPick = srcSegs[s*N_DIG*8 +: N_DIG*8];
                selPick = SW'(s);
            end
    end
    always_comb begin
        content  = paging ? pageSegs[pageIdxNxt*N_DIG*8 +: N_DIG*8] : srcPick;
        blinked  = content;
        for (int d = 0; d < N_DIG; d++)
            blinked[d*8 +: 8] = (!blinkNxt && blinkMask[d]) ? 8'hFF : content[d*8 +: 8];
        loseSegs = '1;
        loseSegs[31:0] = 32'h8692_C0C7;
        segNxt   = loseNxt ? loseSegs : isNone ? '0 : blinked;
        selNxt   = loseNxt ? SW'(N_SRC+1) : paging ? SW'(N_SRC) : selPick;
    end
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            pageCnt    <= '0;
            blinkCnt   <= '0;
            blinkOn    <= 1'b1;
            segOut     <= '1;
            srcSel     <= SW'(N_SRC+1);
            pageIdx    <= '0;
            pageDone   <= 1'b0;
            loseActive <= 1'b0;
        end else begin
            state      <= stateNxt;
            pageCnt    <= pageCntNxt;
            blinkCnt   <= blinkCntNxt;
            blinkOn    <= blinkNxt;
            segOut     <= segNxt;
            srcSel     <= selNxt;
            pageIdx    <= pageIdxNxt;
            pageDone   <= stateNxt == HOLD;
            loseActive <= loseNxt;
        end
    end
endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: directed checks of priority, LOSE latch, page timing, restart and blink.
module tb_seg_display_sched;
    logic Clk100M = 1'b0;
    logic Rst_n = 1'b0;
    logic [2:0] srcValid = '0;
    logic [95:0] srcSegs;
    logic lose = 1'b0, clearLose = 1'b0, pageStart = 1'b0, pageStop = 1'b0;
    logic [95:0] pageSegs;
    logic [3:0] blinkMask = '0;
    logic [31:0] segOut;
    logic [2:0] srcSel;
    logic [1:0] pageIdx;
    logic pageDone, loseActive;
    int nVec = 0, nMis = 0, edges = 0;
    logic [31:0] sv [3] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    logic [31:0] pg [3] = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3};
    localparam logic [31:0] LOSE_PAT = 32'h8692_C0C7;
    assign srcSegs  = {sv[2], sv[1], sv[0]};
    assign pageSegs = {pg[2], pg[1], pg[0]};
    seg_display_sched #(.N_SRC(3), .N_DIG(4), .N_PAGE(3), .PAGE_CYCLES(4), .BLINK_CYCLES(2)) dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .srcValid(srcValid), .srcSegs(srcSegs), .lose(lose),
        .clearLose(clearLose), .pageSegs(pageSegs), .pageStart(pageStart), .pageStop(pageStop),
        .blinkMask(blinkMask), .segOut(segOut), .srcSel(srcSel), .pageIdx(pageIdx),
        .pageDone(pageDone), .loseActive(loseActive)
    );
    always #5 Clk100M = ~Clk100M;
    always @(posedge Clk100M or negedge Rst_n) edges <= !Rst_n ? 0 : edges + 1;
    task automatic tick;
        @(posedge Clk100M);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        tick;
        tick;
        chk("rst_seg", segOut, 32'hFFFF_FFFF);
        chk("rst_sel", 32'(srcSel), 32'd4);
        chk("rst_pidx", 32'(pageIdx), 32'd0);
        chk("rst_done", 32'(pageDone), 32'd0);
        chk("rst_lose", 32'(loseActive), 32'd0);
        Rst_n = 1'b1;
        tick;
        chk("idle_seg", segOut, 32'h0000_0000);
        chk("idle_sel", 32'(srcSel), 32'd4);
        srcValid = 3'b110;
        tick;
        chk("pri110_seg", segOut, sv[1]);
        chk("pri110_sel", 32'(srcSel), 32'd1);
        srcValid = 3'b111;
        tick;
        chk("pri111_seg", segOut, sv[0]);
        chk("pri111_sel", 32'(srcSel), 32'd0);
        srcValid = 3'b000;
        tick;
        chk("none_seg", segOut, 32'h0000_0000);
        chk("none_sel", 32'(srcSel), 32'd4);
        srcValid = 3'b001;
        lose = 1'b1;
        tick;
        lose = 1'b0;
        chk("lose_seg", segOut, LOSE_PAT);
        chk("lose_act", 32'(loseActive), 32'd1);
        chk("lose_sel", 32'(srcSel), 32'd4);
        tick;
        chk("lose_held", segOut, LOSE_PAT);
        lose = 1'b1;
        clearLose = 1'b1;
        tick;
        lose = 1'b0;
        chk("lose_wins", segOut, LOSE_PAT);
        chk("lose_wins_act", 32'(loseActive), 32'd1);
        tick;
        clearLose = 1'b0;
        chk("lose_clr_seg", segOut, sv[0]);
        chk("lose_clr_act", 32'(loseActive), 32'd0);
        chk("lose_clr_sel", 32'(srcSel), 32'd0);
        pageStart = 1'b1;
        tick;
        pageStart = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("page_seg", segOut, pg[k/4]);
            chk("page_idx", 32'(pageIdx), k/4);
            chk("page_done", 32'(pageDone), 32'd0);
            chk("page_sel", 32'(srcSel), 32'd3);
            tick;
        end
        for (int k = 0; k < 20; k++) begin
            chk("hold_seg", segOut, pg[2]);
            chk("hold_idx", 32'(pageIdx), 32'd2);
            chk("hold_done", 32'(pageDone), 32'd1);
            tick;
        end
        pageStop = 1'b1;
        tick;
        pageStop = 1'b0;
        chk("stop_seg", segOut, sv[0]);
        chk("stop_idx", 32'(pageIdx), 32'd0);
        chk("stop_done", 32'(pageDone), 32'd0);
        chk("stop_sel", 32'(srcSel), 32'd0);
        pageStart = 1'b1;
        tick;
        pageStart = 1'b0;
        repeat (5) tick;
        chk("pre_restart", segOut, pg[1]);
        pageStart = 1'b1;
        tick;
        pageStart = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("restart_seg", segOut, pg[k/4]);
            chk("restart_idx", 32'(pageIdx), k/4);
            tick;
        end
        pageStart = 1'b1;
        tick;
        pageStart = 1'b0;
        chk("ovl_p0", segOut, pg[0]);
        lose = 1'b1;
        tick;
        lose = 1'b0;
        chk("ovl_lose", segOut, LOSE_PAT);
        chk("ovl_lose_sel", 32'(srcSel), 32'd4);
        for (int j = 1; j <= 8; j++) begin
            tick;
            chk("ovl_masked", segOut, LOSE_PAT);
            chk("ovl_idx", 32'(pageIdx), (1 + j) / 4);
        end
        clearLose = 1'b1;
        tick;
        clearLose = 1'b0;
        chk("ovl_p2_seg", segOut, pg[2]);
        chk("ovl_p2_idx", 32'(pageIdx), 32'd2);
        chk("ovl_p2_sel", 32'(srcSel), 32'd3);
        chk("ovl_p2_done", 32'(pageDone), 32'd0);
        tick;
        chk("ovl_p2_late", segOut, pg[2]);
        tick;
        chk("ovl_hold_done", 32'(pageDone), 32'd1);
        pageStop = 1'b1;
        tick;
        pageStop = 1'b0;
        lose = 1'b1;
        tick;
        lose = 1'b0;
        chk("pre_arst", segOut, LOSE_PAT);
        Rst_n = 1'b0;
        #2;
        chk("arst_seg", segOut, 32'hFFFF_FFFF);
        chk("arst_sel", 32'(srcSel), 32'd4);
        chk("arst_lose", 32'(loseActive), 32'd0);
        @(negedge Clk100M);
        Rst_n = 1'b1;
        blinkMask = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("blink_edges", 32'(edges), k);
            chk("blink_seg", segOut, ((edges / 2) % 2 == 0) ? sv[0] : (sv[0] | 32'h00FF_00FF));
        end
        lose = 1'b1;
        tick;
        lose = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("blink_lose", segOut, LOSE_PAT);
            tick;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Parametrised seven-segment display scheduler for the game datapath. It selects the segment pattern for an N_DIG-digit display from N_SRC prioritised phase sources, a sticky LOSE override, and a timed page sequencer that rotates through N_PAGE post-game pages and then holds the last one. It also supports per-digit blinking. It sits between the phase controllers (prelim/game/answer/post) and the digit multiplexer driving the board display.

## Interface
Parameters:
- N_SRC, 4, number of prioritised phase sources; index 0 has highest priority.
- N_DIG, 4, number of digits; must be ≥ 4.
- N_PAGE, 4, number of sequencer pages.
- PAGE_CYCLES, 100_000_000, clock cycles each page is shown.
- BLINK_CYCLES, 50_000_000, half-period of the blink, in cycles.

Ports:
- Clk100M  in  1  system clock; all logic on its rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- srcValid  in  N_SRC  per-source request.
- srcSegs  in  N_SRC*N_DIG*8  source s, digit d at bits [(s*N_DIG+d)*8 +: 8].
- lose  in  1  sets the sticky LOSE latch.
- clearLose  in  1  clears the LOSE latch.
- pageSegs  in  N_PAGE*N_DIG*8  page p, digit d at bits [(p*N_DIG+d)*8 +: 8].
- pageStart  in  1  pulse; starts or restarts the page sequence at page 0.
- pageStop  in  1  pulse; aborts the sequence and returns to IDLE.
- blinkMask  in  N_DIG  digits to blink.
- segOut  out  N_DIG*8  registered pattern, active-low segments; digit 0 is leftmost, at [7:0].
- srcSel  out  $clog2(N_SRC+2)  shown content: 0..N_SRC-1 = source, N_SRC = page, N_SRC+1 = LOSE/none.
- pageIdx  out  $clog2(N_PAGE)  current page.
- pageDone  out  1  high while in HOLD.
- loseActive  out  1  LOSE latch state.

## Operation
- **Reset** (Rst_n low, applied asynchronously):
  - segOut = all 0xFF (blank); srcSel = N_SRC+1; pageIdx = 0; pageDone = 0; loseActive = 0.
  - FSM enters IDLE; page and blink counters clear to 0; blink phase is ON.
- **LOSE latch:**
  - Set by lose; cleared by clearLose. If both are high in the same cycle, lose wins.
  - Clears only on clearLose or reset.
- **Display precedence**, evaluated each cycle (first match wins):
  - LOSE: digit0 = 0xC7, digit1 = 0xC0, digit2 = 0x92, digit3 = 0x86, digits ≥ 4 = 0xFF. Blink is not applied.
  - FSM in PAGING or HOLD: pageSegs[pageIdx].
  - Lowest-index s with srcValid[s] set: srcSegs[s].
  - Otherwise: all digits 0x00 (all segments lit); srcSel = N_SRC+1.
- **Blink:**
  - The blink phase toggles every BLINK_CYCLES cycles, free-running from reset.
  - While the phase is OFF, any digit d with blinkMask[d] set is forced to 0xFF.
  - Applies to source and page content only.
- **FSM:**
  - IDLE → PAGING on pageStart: pageIdx = 0, page counter = 0.
  - PAGING: the page counter counts 0..PAGE_CYCLES-1. At terminal count it wraps to 0 and pageIdx increments. Terminal count on page N_PAGE-1 goes to HOLD with pageIdx kept at N_PAGE-1.
  - HOLD: shows the last page indefinitely; pageDone = 1.
  - pageStart in PAGING or HOLD restarts at page 0 with the counter cleared.
  - pageStop in PAGING or HOLD returns to IDLE with pageIdx = 0. If pageStart and pageStop are both high, pageStart wins.
  - The FSM keeps running while LOSE masks the display; paging continues underneath.
- **Widths:** counters are sized with $clog2 of their terminal value. No arithmetic overflow is possible by construction.

## Timing
- All outputs are registered.
- Any input change is reflected in segOut, srcSel and loseActive at the first rising edge after it is sampled (1-cycle latency).
- pageStart sampled at edge t: page 0 appears at edge t+1, then each page lasts exactly PAGE_CYCLES cycles.
- pageIdx is N_PAGE-1 from the start of the last page; pageDone rises PAGE_CYCLES cycles after that.
- The blink phase changes on edges BLINK_CYCLES, 2·BLINK_CYCLES, … after reset release. Masked digits follow on the same edge.
- Rst_n assertion mid-sequence blanks outputs immediately, without waiting for a clock edge. After release the block starts in IDLE.

## Test plan
Bench parameters: N_SRC=3, N_DIG=4, N_PAGE=3, PAGE_CYCLES=4, BLINK_CYCLES=2.

1. **Reset and idle:** hold Rst_n low → segOut = 0xFFFFFFFF, srcSel = 4. Release with no inputs → segOut = 0x00000000 after one edge.
2. **Source priority:** srcValid = 3'b110 → srcSegs[1] shown, srcSel = 1. Then set srcValid[0] → srcSegs[0] shown the next edge. Then srcValid = 0 → all 0x00.
3. **LOSE sticky:** pulse lose for 1 cycle while srcValid = 3'b001 → segOut = {0x86,0x92,0xC0,0xC7} (MSB→LSB), held after lose drops. Assert lose and clearLose together → stays LOSE. Pulse clearLose alone → srcSegs[0] returns the next edge.
4. **Page sequence:** pulse pageStart → pages 0, 1, 2 each shown for exactly 4 cycles; pageDone rises 4 cycles after page 2 starts; page 2 held for 20+ cycles. pageStop → source/default content the next edge, pageIdx = 0.
5. **Restart and lose overlay:** pageStart mid page 1 → page 0 shown the next edge with full 4-cycle duration. lose during page 0 → LOSE shown. clearLose after 9 cycles → page 2 visible, matching the uninterrupted schedule.
6. **Blink:** blinkMask = 4'b0101 with source content → digits 0 and 2 alternate between content and 0xFF every 2 cycles; digits 1 and 3 are steady. Blink is not applied to LOSE.
